// File: rtl/bram_bank_master_if.sv
// -----------------------------------------------------------------------------
// bram_bank_master_if
// Groups the command, response and bank-decoder signals of bram_bank_master.
//   master modport : the bram_bank_master side (accepts commands, returns
//                    responses, drives the bank decoder).
//   slave modport  : the environment side (command source, response sink,
//                    bank decoder read-data mux).
// Signals:
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata/cmd_wstrb : command channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                   : response channel
//   bram_addr/bram_en/bram_we/bram_wdata/bram_rdata         : decoder port
// -----------------------------------------------------------------------------
interface bram_bank_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bram_addr;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, bram_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bram_addr, bram_en, bram_we, bram_wdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, bram_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bram_addr, bram_en, bram_we, bram_wdata
  );
endinterface

// File: rtl/bram_bank_master.sv
// -----------------------------------------------------------------------------
// bram_bank_master
// Single-outstanding command master for a banked BRAM decoder. A command is
// accepted in IDLE, issued as a one-cycle bram_en pulse in ACCESS, read data
// is captured RD_LAT cycles later in WAIT, and the response is held in RESP
// until rsp_ready. Every output is driven straight from a register.
// Parameters:
//   NUM_BANKS : number of 4 KB banks, bank index = addr[19:12]
//   RD_LAT    : cycles from the bram_en cycle to valid bram_rdata (1..3)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bram_bank_master_if.master (command, response, decoder signals)
// Build option:
//   BANK_RANGE_CHK_EN : when defined, a bank index >= NUM_BANKS is answered
//                       with rsp_err=1 and no decoder access; when undefined
//                       no check is made and rsp_err stays 0.
// -----------------------------------------------------------------------------
module bram_bank_master #(
  parameter int NUM_BANKS = 25,
  parameter int RD_LAT    = 1
) (
  input logic                clk,
  input logic                rst_n,
  bram_bank_master_if.master bus
);

  if (RD_LAT < 1 || RD_LAT > 3 || NUM_BANKS < 1 || NUM_BANKS > 256) begin : g_bad_param
    $error("bram_bank_master: RD_LAT must be 1..3 and NUM_BANKS 1..256");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] bram_addr_q, bram_addr_d;
  logic        bram_en_q, bram_en_d;
  logic [3:0]  bram_we_q, bram_we_d;
  logic [31:0] bram_wdata_q, bram_wdata_d;
  logic        oob;

`ifdef BANK_RANGE_CHK_EN
  assign oob = ({24'd0, bus.cmd_addr[19:12]} >= 32'(NUM_BANKS));
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    bram_addr_d  = bram_addr_q;
    bram_en_d    = 1'b0;
    bram_we_d    = 4'h0;
    bram_wdata_d = bram_wdata_q;

    case (state_q)
      // cmd_ready is registered, so it rises on the first clock after reset
      // release or after a response handshake.
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && bus.cmd_valid) begin
          cmd_ready_d = 1'b0;
          we_d        = bus.cmd_we;
          if (oob) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d      = ACCESS;
            bram_en_d    = 1'b1;
            bram_we_d    = bus.cmd_we ? bus.cmd_wstrb : 4'h0;
            bram_addr_d  = bus.cmd_addr & 32'hFFFF_FFFC;
            bram_wdata_d = bus.cmd_wdata;
          end
        end
      end
      // bram_en is high for this single cycle only.
      ACCESS: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'(RD_LAT);
        end
      end
      // bram_addr is still held here so the decoder mux keeps the bank.
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d     = RESP;
          cnt_d       = 2'd0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.bram_rdata;
          rsp_err_d   = 1'b0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      we_q         <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
      bram_addr_q  <= 32'h0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 4'h0;
      bram_wdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      bram_addr_q  <= bram_addr_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_wdata = bram_wdata_q;

endmodule

// File: tb/tb_bram_bank_master.sv
// -----------------------------------------------------------------------------
// tb_bram_bank_master
// Two instances: u_dut1 (RD_LAT=1) runs the vector table, the reset-in-WAIT
// sequence and the reset-state checks; u_dut3 (RD_LAT=3) runs the long
// response-backpressure sequence. A small decoder model per instance returns
// the expected read word only in the cycle RD_LAT after bram_en and only while
// bram_addr still points at the expected word; otherwise it returns DEADBEEF.
// -----------------------------------------------------------------------------
module tb_bram_bank_master;

`ifdef BANK_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_bank_master_if bus1();
  bram_bank_master_if bus3();

  bram_bank_master #(.NUM_BANKS(25), .RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  bram_bank_master #(.NUM_BANKS(25), .RD_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Decoder models
  logic [2:0]  pipe1_q = 3'b000;
  logic [2:0]  pipe3_q = 3'b000;
  logic [31:0] rd_val1 = 32'h0, exp_addr1 = 32'h0, rd_val3 = 32'h0, exp_addr3 = 32'h0;
  always @(posedge clk) begin
    pipe1_q <= {pipe1_q[1:0], bus1.bram_en && (bus1.bram_we == 4'h0)};
    pipe3_q <= {pipe3_q[1:0], bus3.bram_en && (bus3.bram_we == 4'h0)};
  end
  assign bus1.bram_rdata = (pipe1_q[0] && bus1.bram_addr == exp_addr1) ? rd_val1 : 32'hDEAD_BEEF;
  assign bus3.bram_rdata = (pipe3_q[2] && bus3.bram_addr == exp_addr3) ? rd_val3 : 32'hDEAD_BEEF;

  logic any1, any3;
  assign any1 = bus1.cmd_ready | bus1.rsp_valid | (|bus1.rsp_rdata) | bus1.rsp_err |
                (|bus1.bram_addr) | bus1.bram_en | (|bus1.bram_we) | (|bus1.bram_wdata);
  assign any3 = bus3.cmd_ready | bus3.rsp_valid | (|bus3.rsp_rdata) | bus3.rsp_err |
                (|bus3.bram_addr) | bus3.bram_en | (|bus3.bram_we) | (|bus3.bram_wdata);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rd_val;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr;
    int          exp_rsp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  vec_t v[8];

  initial begin #200000; $display("FAIL watchdog actual=timeout required=finish"); $fatal(1, "watchdog"); end

  initial begin
    int n, en_cnt, en_cyc, rsp_cyc;
    logic busy_ready, stable, saw_bad;
    logic [3:0]  en_we;
    logic [31:0] en_addr, en_wdata, r_rdata;
    logic        r_err;

    v[0] = '{1'b0, 32'h0000_3010, 32'h0,         4'h0, 32'hA5A5_0003, 1'b1, 4'h0, 32'h0000_3010, 3, 32'hA5A5_0003, 1'b0, 0};
    v[1] = '{1'b1, 32'h0001_8004, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 4'hF, 32'h0001_8004, 2, 32'h0,         1'b0, 0};
    v[2] = '{1'b1, 32'h0000_5000, 32'h5555_AAAA, 4'h0, 32'h0,         1'b1, 4'h0, 32'h0000_5000, 2, 32'h0,         1'b0, 1};
    v[3] = '{1'b1, 32'h0000_2007, 32'hCAFE_F00D, 4'h5, 32'h0,         1'b1, 4'h5, 32'h0000_2004, 2, 32'h0,         1'b0, 0};
    v[4] = '{1'b0, 32'h0001_9000, 32'h0,         4'h0, 32'h0,         !CHK, 4'h0, 32'h0001_9000, CHK ? 1 : 3, 32'h0, CHK, 0};
    v[5] = '{1'b0, 32'h0001_8FFC, 32'h0,         4'h0, 32'h1111_2222, 1'b1, 4'h0, 32'h0001_8FFC, 3, 32'h1111_2222, 1'b0, 2};
    v[6] = '{1'b1, 32'hFFFF_F000, 32'h0BAD_0BAD, 4'hF, 32'h0,         !CHK, 4'hF, 32'hFFFF_F000, CHK ? 1 : 2, 32'h0, CHK, 0};
    v[7] = '{1'b0, 32'h0000_0FFE, 32'h0,         4'h0, 32'h8000_0001, 1'b1, 4'h0, 32'h0000_0FFC, 3, 32'h8000_0001, 1'b0, 3};

    // Reset state
    rst_n = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_we = 1'b0; bus1.cmd_addr = 32'h0; bus1.cmd_wdata = 32'h0;
    bus1.cmd_wstrb = 4'h0; bus1.rsp_ready = 1'b0;
    bus3.cmd_valid = 1'b0; bus3.cmd_we = 1'b0; bus3.cmd_addr = 32'h0; bus3.cmd_wdata = 32'h0;
    bus3.cmd_wstrb = 4'h0; bus3.rsp_ready = 1'b0;
    #12;
    chk("reset_outputs_dut1", {31'b0, any1}, 32'h0);
    chk("reset_outputs_dut3", {31'b0, any3}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'b0, bus1.cmd_ready}, 32'h1);

    // Vector table on the RD_LAT=1 instance
    for (int i = 0; i < 8; i++) begin
      rd_val1 = v[i].rd_val; exp_addr1 = v[i].exp_addr;
      n = 0;
      while (!bus1.cmd_ready && n < 10) begin @(negedge clk); n++; end
      chk($sformatf("v%0d_cmd_ready", i), {31'b0, bus1.cmd_ready}, 32'h1);
      bus1.cmd_valid = 1'b1; bus1.cmd_we = v[i].we; bus1.cmd_addr = v[i].addr;
      bus1.cmd_wdata = v[i].wdata; bus1.cmd_wstrb = v[i].wstrb;
      @(posedge clk); #1;
      bus1.cmd_valid = 1'b0; bus1.cmd_addr = 32'h0; bus1.cmd_wdata = 32'h0; bus1.cmd_wstrb = 4'h0;
      en_cnt = 0; en_cyc = 0; rsp_cyc = 0; busy_ready = 1'b0;
      en_we = 4'h0; en_addr = 32'h0; en_wdata = 32'h0; r_rdata = 32'h0; r_err = 1'b0;
      for (int k = 1; k <= 10 && rsp_cyc == 0; k++) begin
        @(negedge clk);
        if (bus1.cmd_ready) busy_ready = 1'b1;
        if (bus1.bram_en) begin
          en_cnt++; en_cyc = k; en_we = bus1.bram_we; en_addr = bus1.bram_addr; en_wdata = bus1.bram_wdata;
        end
        if (bus1.rsp_valid) begin rsp_cyc = k; r_rdata = bus1.rsp_rdata; r_err = bus1.rsp_err; end
      end
      stable = 1'b1;
      for (int h = 0; h < v[i].hold; h++) begin
        @(negedge clk);
        if (!bus1.rsp_valid || bus1.rsp_rdata !== r_rdata || bus1.rsp_err !== r_err) stable = 1'b0;
        if (bus1.cmd_ready) busy_ready = 1'b1;
        if (bus1.bram_en) en_cnt++;
      end
      chk($sformatf("v%0d_en_count", i), en_cnt, {31'b0, v[i].exp_en});
      if (v[i].exp_en) begin
        chk($sformatf("v%0d_en_cycle", i), en_cyc, 32'd1);
        chk($sformatf("v%0d_bram_we", i), {28'b0, en_we}, {28'b0, v[i].exp_we});
        chk($sformatf("v%0d_bram_addr", i), en_addr, v[i].exp_addr);
        if (v[i].we) chk($sformatf("v%0d_bram_wdata", i), en_wdata, v[i].wdata);
      end
      chk($sformatf("v%0d_rsp_cycle", i), rsp_cyc, v[i].exp_rsp_cyc);
      chk($sformatf("v%0d_rsp_rdata", i), r_rdata, v[i].exp_rdata);
      chk($sformatf("v%0d_rsp_err", i), {31'b0, r_err}, {31'b0, v[i].exp_err});
      chk($sformatf("v%0d_busy_ready", i), {31'b0, busy_ready}, 32'h0);
      chk($sformatf("v%0d_rsp_stable", i), {31'b0, stable}, 32'h1);
      bus1.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus1.rsp_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_drop", i), {31'b0, bus1.rsp_valid}, 32'h0);
      chk($sformatf("v%0d_ready_next", i), {31'b0, bus1.cmd_ready}, 32'h1);
    end

    // RD_LAT=3 read, response held off for 5 cycles, stray cmd_valid meanwhile
    rd_val3 = 32'h3C3C_0007; exp_addr3 = 32'h0000_4020;
    n = 0;
    while (!bus3.cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("lat3_cmd_ready", {31'b0, bus3.cmd_ready}, 32'h1);
    bus3.cmd_valid = 1'b1; bus3.cmd_we = 1'b0; bus3.cmd_addr = 32'h0000_4020;
    @(posedge clk); #1;
    bus3.cmd_valid = 1'b0;
    en_cnt = 0; en_cyc = 0; rsp_cyc = 0; busy_ready = 1'b0; r_rdata = 32'h0; r_err = 1'b0;
    for (int k = 1; k <= 10 && rsp_cyc == 0; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus3.cmd_valid = 1'b1; bus3.cmd_we = 1'b1; bus3.cmd_addr = 32'h0000_0100; bus3.cmd_wstrb = 4'hF;
      end
      if (bus3.cmd_ready) busy_ready = 1'b1;
      if (bus3.bram_en) begin en_cnt++; en_cyc = k; end
      if (bus3.rsp_valid) begin rsp_cyc = k; r_rdata = bus3.rsp_rdata; r_err = bus3.rsp_err; end
    end
    stable = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      if (!bus3.rsp_valid || bus3.rsp_rdata !== r_rdata || bus3.rsp_err !== r_err) stable = 1'b0;
      if (bus3.cmd_ready) busy_ready = 1'b1;
      if (bus3.bram_en) en_cnt++;
    end
    chk("lat3_en_count", en_cnt, 32'd1);
    chk("lat3_en_cycle", en_cyc, 32'd1);
    chk("lat3_rsp_cycle", rsp_cyc, 32'd5);
    chk("lat3_rsp_rdata", r_rdata, 32'h3C3C_0007);
    chk("lat3_rsp_err", {31'b0, r_err}, 32'h0);
    chk("lat3_rsp_stable", {31'b0, stable}, 32'h1);
    chk("lat3_busy_ready", {31'b0, busy_ready}, 32'h0);
    bus3.cmd_valid = 1'b0; bus3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus3.rsp_ready = 1'b0;
    @(negedge clk);
    chk("lat3_ready_next", {31'b0, bus3.cmd_ready}, 32'h1);
    saw_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus3.bram_en || bus3.rsp_valid) saw_bad = 1'b1;
    end
    chk("lat3_stray_cmd_ignored", {31'b0, saw_bad}, 32'h0);

    // Reset asserted during WAIT of a RD_LAT=1 read
    rd_val1 = 32'h7777_0001; exp_addr1 = 32'h0000_6000;
    chk("rst_wait_cmd_ready", {31'b0, bus1.cmd_ready}, 32'h1);
    bus1.cmd_valid = 1'b1; bus1.cmd_we = 1'b0; bus1.cmd_addr = 32'h0000_6000;
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
    @(posedge clk); #2;
    chk("rst_wait_pre_en", {31'b0, bus1.bram_en}, 32'h0);
    chk("rst_wait_pre_addr", bus1.bram_addr, 32'h0000_6000);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_outputs_zero", {31'b0, any1}, 32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_wait_ready_before_clk", {31'b0, bus1.cmd_ready}, 32'h0);
    @(posedge clk); #1;
    chk("rst_wait_ready_first_clk", {31'b0, bus1.cmd_ready}, 32'h1);
    saw_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus1.bram_en || bus1.rsp_valid) saw_bad = 1'b1;
    end
    chk("rst_wait_dropped", {31'b0, saw_bad}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
